bist_misr_analyzer: RTL and testbench
=====================================

// Module: bist_misr_analyzer
// PURPOSE
//  Output-response analyser for the LFSR BIST: the receive end of the pattern path. The LFSR
//  pattern generator drives the CUT; this block takes the CUT responses, compresses them into
//  a MISR signature, and compares that signature against a golden value. It reports busy,
//  done and pass/fail, and the top level maps these to the LED bank.
// PARAMETERS
//  WIDTH          16        response and signature width, in bits
//  POLY           16'h1021  Galois feedback mask (x^16+x^12+x^5+1)
//  SEED           16'h0000  signature value loaded on reset and on start
//  PATTERN_COUNT  65535     number of accepted responses per run; must be >= 1
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-low (0 = in reset)
//  start       in   1      one-cycle pulse that begins or restarts a run
//  resp_valid  in   1      resp_data holds a CUT response
//  resp_data   in   WIDTH  CUT response word
//  resp_ready  out  1      analyser can accept a response (high only in CAPTURE)
//  golden_sig  in   WIDTH  expected signature; sampled in the COMPARE cycle
//  signature   out  WIDTH  current MISR contents
//  busy        out  1      high in CAPTURE and COMPARE
//  done        out  1      high in DONE
//  pass        out  1      DONE and signature == golden_sig
//  fail        out  1      DONE and signature != golden_sig
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, signature=SEED, count=0, pass/fail/done/busy/resp_ready=0.
//  FSM states: IDLE, CAPTURE, COMPARE, DONE. All transitions are registered.
//   IDLE    -> CAPTURE on start. Loads signature=SEED and count=0.
//   CAPTURE -> accepts a response when resp_valid & resp_ready. On each accept:
//              sig' = ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ resp_data
//              count' = count+1.
//              Moves to COMPARE on the accept that brings count to PATTERN_COUNT.
//   COMPARE -> one cycle. Registers match = (signature == golden_sig). Moves to DONE.
//   DONE    -> holds signature, pass and fail until the next start or a reset.
//  start in any state (including mid-run) aborts the run:
//   - next cycle: state=CAPTURE, signature=SEED, count=0, pass=fail=0.
//   - start has priority: a response offered in the same cycle as start is not accepted.
//  resp_valid is ignored in IDLE, COMPARE and DONE. No signature update occurs in those states.
//  resp_ready is combinational from the state (state==CAPTURE); it never depends on resp_valid.
//  Response latency: an accepted word appears in signature on the next cycle.
//  done rises 2 cycles after the final accept (1 cycle in CAPTURE->COMPARE, 1 in COMPARE->DONE).
//  Count register width: $clog2(PATTERN_COUNT+1). It never wraps within a run.
//  pass and fail are mutually exclusive and are never both 0 while done=1.
//  Reset asserted mid-run: all state clears immediately (asynchronous). No partial result is kept.
// STRUCTURE
//  bist_pkg: state encodings (IDLE=2'd0, CAPTURE=2'd1, COMPARE=2'd2, DONE=2'd3),
//   plus the default POLY and SEED constants that are shared with the LFSR generator.
//  Sub-module misr_core (WIDTH, POLY): signature register with load/seed and enable/update
//   inputs, and the same asynchronous active-low reset. The FSM and counter stay in this module.
// TESTING
//  1 Reset: rst=0 mid-stream -> signature=SEED, all status outputs 0, resp_ready=0.
//  2 Update math: SEED=0, PATTERN_COUNT=3, responses 16'h8000, 0, 0 ->
//    signature is 16'h8000, then 16'h1021, then 16'h2042; done rises 2 cycles after the 3rd accept.
//  3 Compare: repeat test 2 with golden_sig=16'h2042 -> pass=1, fail=0.
//    Rerun with golden_sig=16'h2043 -> fail=1, pass=0.
//  4 Handshake: toggle resp_valid randomly during CAPTURE ->
//    only valid&ready cycles update signature/count, so the result equals test 2.
//    resp_valid=1 in IDLE and DONE -> signature unchanged.
//  5 Abort: start after 2 accepts, together with resp_valid=1 ->
//    the response is not accepted, signature=SEED, count=0; a fresh 3-word run reproduces 16'h2042.
//  6 Full run with defaults: responses from the LFSR generator through an identity CUT ->
//    signature matches the reference model; a single-bit fault injected at word 1000 -> fail=1.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: analyser state encoding and the POLY/SEED defaults shared with the LFSR generator.
package bist_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;
endpackage

// File: rtl/misr_core.sv
// misr_core: Galois MISR signature register with seed load and gated update.
module misr_core import bist_pkg::*; #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o
);
  logic [WIDTH-1:0] sig_q, sig_d, step;
  assign step  = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_i;
  assign sig_d = load_i ? SEED : en_i ? step : sig_q;
  assign sig_o = sig_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  end
endmodule

// File: rtl/bist_misr_analyzer.sv
// bist_misr_analyzer: compresses CUT responses into a MISR signature and checks it against a golden value.
module bist_misr_analyzer import bist_pkg::*; #(
  parameter int unsigned      WIDTH         = 16,
  parameter logic [WIDTH-1:0] POLY          = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(DEF_SEED),
  parameter int unsigned      PATTERN_COUNT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             resp_valid_i,
  input  logic [WIDTH-1:0] resp_data_i,
  output logic             resp_ready_o,
  input  logic [WIDTH-1:0] golden_sig_i,
  output logic [WIDTH-1:0] signature_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o
);
  localparam int unsigned CW = $clog2(PATTERN_COUNT + 1);
  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            match_q, match_d;
  logic            accept;
  // start outranks any response offered in the same cycle
  assign accept = resp_ready_o & resp_valid_i & ~start_i;
  misr_core #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_i),
    .en_i   (accept),
    .data_i (resp_data_i),
    .sig_o  (signature_o)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    match_d = match_q;
    if (start_i) begin
      state_d = CAPTURE;
      count_d = '0;
      match_d = 1'b0;
    end else begin
      unique case (state_q)
        CAPTURE: if (accept) begin
          count_d = count_q + 1'b1;
          state_d = (count_q == CW'(PATTERN_COUNT - 1)) ? COMPARE : CAPTURE;
        end
        COMPARE: begin
          match_d = (signature_o == golden_sig_i);
          state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end
  assign resp_ready_o = (state_q == CAPTURE);
  assign busy_o       = (state_q == CAPTURE) | (state_q == COMPARE);
  assign done_o       = (state_q == DONE);
  assign pass_o       = done_o & match_q;
  assign fail_o       = done_o & ~match_q;
endmodule

// File: tb/tb_bist_misr_analyzer.sv
// tb_bist_misr_analyzer: model-checked small run (PATTERN_COUNT=3) plus full default-size good/faulty runs.
module tb_bist_misr_analyzer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  logic        s_start, s_valid, s_ready, s_busy, s_done, s_pass, s_fail;
  logic [15:0] s_data, s_golden, s_sig;
  logic        f_start, f_valid;
  logic [15:0] fa_data, fb_data, f_golden, fa_sig, fb_sig;
  logic        fa_ready, fa_busy, fa_done, fa_pass, fa_fail;
  logic        fb_ready, fb_busy, fb_done, fb_pass, fb_fail;
  bist_misr_analyzer #(.WIDTH(16), .POLY(16'h1021), .SEED(16'h0000), .PATTERN_COUNT(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .resp_valid_i(s_valid), .resp_data_i(s_data),
    .resp_ready_o(s_ready), .golden_sig_i(s_golden), .signature_o(s_sig), .busy_o(s_busy),
    .done_o(s_done), .pass_o(s_pass), .fail_o(s_fail));
  bist_misr_analyzer dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(f_start), .resp_valid_i(f_valid), .resp_data_i(fa_data),
    .resp_ready_o(fa_ready), .golden_sig_i(f_golden), .signature_o(fa_sig), .busy_o(fa_busy),
    .done_o(fa_done), .pass_o(fa_pass), .fail_o(fa_fail));
  bist_misr_analyzer dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(f_start), .resp_valid_i(f_valid), .resp_data_i(fb_data),
    .resp_ready_o(fb_ready), .golden_sig_i(f_golden), .signature_o(fb_sig), .busy_o(fb_busy),
    .done_o(fb_done), .pass_o(fb_pass), .fail_o(fb_fail));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // signature polynomial arithmetic: multiply by x modulo x^16+x^12+x^5+1, then add the word
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
    logic [16:0] p;
    p = {s, 1'b0};
    if (p[16]) p = p ^ 17'h11021;
    return p[15:0] ^ d;
  endfunction
  int          m_ph;
  int          m_cnt;
  logic [15:0] m_sig;
  logic        m_match;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_cnt <= 0; m_sig <= 16'h0; m_match <= 1'b0;
    end else if (s_start) begin
      m_ph <= 1; m_cnt <= 0; m_sig <= 16'h0;
    end else if (m_ph == 1 && s_valid) begin
      m_sig <= misr(m_sig, s_data);
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == 3) m_ph <= 2;
    end else if (m_ph == 2) begin
      m_match <= (m_sig == s_golden);
      m_ph <= 3;
    end
  end
  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      chk("cyc_sig", s_sig, m_sig);
      chk("cyc_ready", s_ready, m_ph == 1);
      chk("cyc_busy", s_busy, m_ph == 1 || m_ph == 2);
      chk("cyc_done", s_done, m_ph == 3);
      chk("cyc_pass", s_pass, m_ph == 3 && m_match);
      chk("cyc_fail", s_fail, m_ph == 3 && !m_match);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run3(input logic [15:0] g);
    s_golden = g;
    s_start = 1'b1; step(); s_start = 1'b0;
    chk("run_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 16'h8000; step();
    chk("run_sig1", s_sig, 16'h8000);
    s_data = 16'h0000; step();
    chk("run_sig2", s_sig, 16'h1021);
    step();
    chk("run_sig3", s_sig, 16'h2042);
    chk("run_done_plus1", s_done, 0);
    chk("run_busy_plus1", s_busy, 1);
    s_valid = 1'b0; step();
    chk("run_done_plus2", s_done, 1);
  endtask
  logic [15:0] words[65535];
  logic [15:0] ref_sig;
  initial begin
    logic [15:0] x;
    logic [15:0] w[3];
    int i, n;
    w[0] = 16'h8000; w[1] = 16'h0000; w[2] = 16'h0000;
    x = 16'hACE1;
    ref_sig = 16'h0000;
    for (int k = 0; k < 65535; k++) begin
      words[k] = x;
      ref_sig = misr(ref_sig, x);
      x = {x[14:0], 1'b0} ^ (x[15] ? 16'h1021 : 16'h0000);
    end
    rst_n = 1'b1;
    s_start = 0; s_valid = 0; s_data = 0; s_golden = 0;
    f_start = 0; f_valid = 0; fa_data = 0; fb_data = 0; f_golden = ref_sig;
    #2 rst_n = 1'b0;
    step(); step();
    chk("reset_sig", s_sig, 16'h0);
    chk("reset_ready", s_ready, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_done", s_done, 0);
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 16'hFFFF; step(); step();
    chk("idle_hold_sig", s_sig, 16'h0);
    chk("idle_hold_ready", s_ready, 0);
    s_valid = 1'b0;
    run3(16'h2042);
    chk("cmp_pass", s_pass, 1);
    chk("cmp_pass_fail", s_fail, 0);
    s_valid = 1'b1; s_data = 16'h1234; step(); step();
    chk("done_hold_sig", s_sig, 16'h2042);
    chk("done_hold_pass", s_pass, 1);
    s_valid = 1'b0;
    run3(16'h2043);
    chk("cmp_fail", s_fail, 1);
    chk("cmp_fail_pass", s_pass, 0);
    s_golden = 16'h2042;
    s_start = 1'b1; step(); s_start = 1'b0;
    i = 0;
    for (int c = 0; c < 60 && i < 3; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = s_valid ? w[i] : 16'($urandom);
      step();
      if (s_valid) i++;
    end
    s_valid = 1'b0;
    n = 0;
    while (!s_done && n < 5) begin step(); n++; end
    chk("hs_done", s_done, 1);
    chk("hs_sig", s_sig, 16'h2042);
    chk("hs_pass", s_pass, 1);
    s_start = 1'b1; step(); s_start = 1'b0;
    s_valid = 1'b1; s_data = 16'h8000; step();
    s_data = 16'h0000; step();
    chk("abort_pre_sig", s_sig, 16'h1021);
    s_start = 1'b1; s_data = 16'hFFFF; step(); s_start = 1'b0;
    chk("abort_sig", s_sig, 16'h0);
    chk("abort_busy", s_busy, 1);
    for (int k = 0; k < 3; k++) begin s_data = w[k]; step(); end
    s_valid = 1'b0;
    chk("abort_rerun_sig", s_sig, 16'h2042);
    step();
    chk("abort_rerun_pass", s_pass, 1);
    s_start = 1'b1; step(); s_start = 1'b0;
    s_valid = 1'b1; s_data = 16'h8000; step();
    chk("midrst_pre_sig", s_sig, 16'h8000);
    rst_n = 1'b0; #1;
    chk("midrst_sig", s_sig, 16'h0);
    chk("midrst_busy", s_busy, 0);
    chk("midrst_ready", s_ready, 0);
    chk("midrst_done", s_done, 0);
    s_valid = 1'b0;
    step(); rst_n = 1'b1; step();
    chk("midrst_idle_ready", s_ready, 0);
    f_start = 1'b1; step(); f_start = 1'b0;
    f_valid = 1'b1;
    for (int k = 0; k < 65535; k++) begin
      fa_data = words[k];
      fb_data = (k == 1000) ? (words[k] ^ 16'h0001) : words[k];
      step();
    end
    f_valid = 1'b0;
    n = 0;
    while (!(fa_done && fb_done) && n < 5) begin step(); n++; end
    chk("full_done", fa_done, 1);
    chk("full_sig", fa_sig, ref_sig);
    chk("full_pass", fa_pass, 1);
    chk("full_fail_clear", fa_fail, 0);
    chk("fault_done", fb_done, 1);
    chk("fault_fail", fb_fail, 1);
    chk("fault_pass", fb_pass, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
